// File: rtl/job_dispatcher.sv
// Job/solution host transmitter: streams midstate + header words to the miner core and collects its nonce.
// Optional SOL_SYNC_EN: pass sol_claim/out_data through a 2-flop synchronizer.
module job_dispatcher #(
  parameter int MID_WORDS      = 8,
  parameter int HEAD_WORDS     = 16,
  parameter int TIMEOUT_CYCLES = 1048576,
  parameter int TO_W           = 21
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [32*MID_WORDS-1:0]   job_mid,
  input  logic [32*HEAD_WORDS-1:0]  job_head,
  input  logic                      abort,
  output logic                      start_found,
  output logic [31:0]               in_data,
  input  logic                      sol_claim,
  input  logic [31:0]               out_data,
  output logic                      sol_response,
  output logic                      res_valid,
  output logic                      res_found,
  output logic [31:0]               res_nonce
);

  localparam int TOT_WORDS = MID_WORDS + HEAD_WORDS;
  localparam int SH_W      = 32 * TOT_WORDS;
  localparam int CNT_W     = $clog2(TOT_WORDS + 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(MID_WORDS);
  localparam logic [CNT_W-1:0] CNT_TOT  = CNT_W'(TOT_WORDS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, START, MID, HEAD, WAIT, ACK} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [TO_W-1:0]   tcnt, tcnt_n;
  logic [SH_W-1:0]   shreg;
  logic              load, shift;
  logic              start_n, resp_n, rv_n, rf_n;
  logic [31:0]       data_n, nonce_n;
  logic              claim;
  logic [31:0]       nonce;

`ifdef SOL_SYNC_EN
  logic        claim_p0, claim_p1;
  logic [31:0] nonce_p0, nonce_p1;

  // Synchronizer stages p0 -> p1 for the claim and its nonce
  always_ff @(posedge clk) begin
    if (rst) begin
      claim_p0 <= 1'b0;
      claim_p1 <= 1'b0;
    end else begin
      claim_p0 <= sol_claim;
      claim_p1 <= claim_p0;
    end
  end

  always_ff @(posedge clk) begin
    nonce_p0 <= out_data;
    nonce_p1 <= nonce_p0;
  end

  assign claim = claim_p1;
  assign nonce = nonce_p1;
`else
  assign claim = sol_claim;
  assign nonce = out_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Outputs are computed for the next state and registered on the same edge.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tcnt_n  = tcnt;
    load    = 1'b0;
    shift   = 1'b0;
    start_n = 1'b0;
    resp_n  = 1'b0;
    rv_n    = 1'b0;
    rf_n    = 1'b0;
    data_n  = 32'h0;
    nonce_n = res_nonce;
    case (state)
      IDLE: begin
        if (job_valid && job_ready && !abort) begin
          state_n = START;
          load    = 1'b1;
          start_n = 1'b1;
          cnt_n   = '0;
        end
      end
      START: begin
        state_n = MID;
        data_n  = shreg[SH_W-1 -: 32];
        shift   = 1'b1;
        cnt_n   = CNT_W'(1);
      end
      MID: begin
        data_n = shreg[SH_W-1 -: 32];
        shift  = 1'b1;
        cnt_n  = cnt + 1'b1;
        if (cnt == CNT_MID) state_n = HEAD;
      end
      HEAD: begin
        if (cnt == CNT_TOT) begin
          state_n = WAIT;
          tcnt_n  = '0;
        end else begin
          data_n = shreg[SH_W-1 -: 32];
          shift  = 1'b1;
          cnt_n  = cnt + 1'b1;
        end
      end
      WAIT: begin
        tcnt_n = tcnt + 1'b1;
        if (claim) begin
          state_n = ACK;
          nonce_n = nonce;
          resp_n  = 1'b1;
        end else if (tcnt == TO_LAST) begin
          state_n = IDLE;
          rv_n    = 1'b1;
          nonce_n = 32'h0;
        end
      end
      ACK: begin
        if (claim) begin
          resp_n = 1'b1;
        end else begin
          state_n = IDLE;
          rv_n    = 1'b1;
          rf_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // Abort overrides claim and timeout and suppresses any result.
    if (abort && state != IDLE) begin
      state_n = IDLE;
      shift   = 1'b0;
      start_n = 1'b0;
      resp_n  = 1'b0;
      rv_n    = 1'b0;
      rf_n    = 1'b0;
      data_n  = 32'h0;
      nonce_n = res_nonce;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      tcnt         <= '0;
      job_ready    <= 1'b1;
      start_found  <= 1'b0;
      sol_response <= 1'b0;
      res_valid    <= 1'b0;
      res_found    <= 1'b0;
      in_data      <= 32'h0;
      res_nonce    <= 32'h0;
    end else begin
      cnt          <= cnt_n;
      tcnt         <= tcnt_n;
      job_ready    <= (state_n == IDLE);
      start_found  <= start_n;
      sol_response <= resp_n;
      res_valid    <= rv_n;
      res_found    <= rf_n;
      in_data      <= data_n;
      res_nonce    <= nonce_n;
    end
  end

  // Word shift register: MSW of the midstate leaves first, header follows.
  always_ff @(posedge clk) begin
    if (load)       shreg <= {job_mid, job_head};
    else if (shift) shreg <= {shreg[SH_W-33:0], 32'h0};
  end

endmodule
